a2bus_capture_packer: RTL and testbench
=======================================

# a2bus_capture_packer

Upstream feeder for the 4-bit ESP32 stream FIFO. Takes one-cycle Apple II bus-cycle strobes (address, data, R/W) and filters them against a configurable address window. Packs each accepted cycle into a 32-bit tagged word and writes it into the stream FIFO. Under FIFO backpressure it drops captures, counts them, and inserts a drop-report word once space returns, so the ESP32 side can detect and size every gap.

## Interface
Parameters:
- ADDR_LO, 16'hC000, lowest captured address (inclusive)
- ADDR_HI, 16'hC0FF, highest captured address (inclusive)
- CAPTURE_READS, 1, 1 = capture reads and writes; 0 = writes only

Ports:
- clk  in  1  system clock (54 MHz domain, same as stream FIFO)
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable; low suppresses new captures only
- bus_strobe  in  1  one-cycle pulse per completed bus cycle
- bus_addr  in  16  address, valid with bus_strobe
- bus_data  in  8  data, valid with bus_strobe
- bus_rw_n  in  1  1 = read, 0 = write, valid with bus_strobe
- fifo_full  in  1  stream FIFO full
- fifo_almost_full  in  1  stream FIFO count >= depth-2
- clear_stats  in  1  one-cycle pulse; clears drop_count and overflow_flag
- fifo_wr_en  out  1  one-cycle write pulse to stream FIFO
- fifo_data_out  out  32  word written when fifo_wr_en=1
- drop_count  out  16  total dropped captures, saturating at 16'hFFFF
- overflow_flag  out  1  sticky; set on any drop

## Operation
- match = enable & bus_strobe & (ADDR_LO <= bus_addr <= ADDR_HI) & (!bus_rw_n | CAPTURE_READS).
- space = !fifo_almost_full & !fifo_full. The almost_full margin covers the registered write path.
- DATA word: [31:28]=4'hA, [27]=rw_n, [26:24]=seq, [23:8]=addr, [7:0]=data.
  - seq is a 3-bit counter that increments after each DATA word, wrapping 7→0.
- DROP word: [31:28]=4'hD, [27:16]=12'h000, [15:0]=pending.
  - pending is the 16-bit count of drops since the last DROP word, saturating at 16'hFFFF.
  - A DROP word does not advance seq.
- State RUN:
  - match & space → emit DATA word next cycle.
  - match & !space → pending=1, drop_count+1 (saturating), overflow_flag=1, go to DRAIN.
  - No match → idle.
- State DRAIN:
  - Every match is dropped and counted into pending and drop_count, whether or not space is present.
  - space → emit DROP word carrying pending, including any match dropped that same cycle.
    - If a match occurs in the emission cycle, pending restarts at 1 and the state stays DRAIN.
    - Otherwise pending=0 and the state goes to RUN.
  - !space → remain in DRAIN.
- enable low does not block DRAIN; pending drops are still reported.
- clear_stats zeroes drop_count and overflow_flag only. It does not touch pending, seq, or state.
  - If clear_stats coincides with a drop, the clear wins for that cycle and the drop is lost from drop_count. It is still reported in pending.

## Timing
- Reset state: RUN, seq=0, pending=0.
- Reset values: fifo_wr_en=0, fifo_data_out=32'h0, drop_count=0, overflow_flag=0.
- DATA latency: fifo_wr_en and fifo_data_out are registered, one cycle after the strobe.
- Back-to-back strobes on consecutive cycles are fully supported: one word per cycle.
- DROP latency: the DROP word is emitted one cycle after the first DRAIN cycle in which space=1.
- fifo_data_out holds its last value when fifo_wr_en=0.
- fifo_wr_en is never asserted in a cycle following one where space=0 was sampled for that decision.
- Reset asserted mid-DRAIN discards pending. The next cycle, fifo_wr_en=0.

## Test plan
- **Filter:**
  - Stimulus: strobes at C030 (write, 8'h5A), BFFF, C100, and C0FF (read, 8'h11) with CAPTURE_READS=1.
  - Required: exactly two writes, 32'hA0C0305A then 32'hA9C0FF11 (seq 0 then 1), each one cycle after its strobe.
  - Rerun with CAPTURE_READS=0: only the first write appears.
- **Seq wrap:**
  - Stimulus: 9 back-to-back matching strobes with space held.
  - Required: 9 consecutive fifo_wr_en cycles; seq field reads 0..7 then 0.
- **Backpressure:**
  - Stimulus: fifo_almost_full=1; send 3 matching strobes; release almost_full.
  - Required: next cycle writes 32'hD0000003; drop_count=3, overflow_flag=1.
  - The following match produces a DATA word with seq continuing unchanged.
- **Drop during emission:**
  - Stimulus: in DRAIN with pending=2, release space in the same cycle as a match.
  - Required: 32'hD0000003 is written, the next cycle writes 32'hD0000001, then the state returns to RUN.
- **Saturation and clear:**
  - Stimulus: force 70000 drops.
  - Required: drop_count=16'hFFFF and the DROP word shows 16'hFFFF.
  - A clear_stats pulse then gives drop_count=0 and overflow_flag=0.
- **Reset mid-operation:**
  - Stimulus: assert rst in DRAIN with pending=5.
  - Required: all outputs return to 0 the next cycle and no DROP word is emitted.
  - The first post-reset match writes seq=0.

Source files
------------

// File: rtl/a2bus_capture_packer.sv
// ---------------------------------------------------------------------------
// a2bus_capture_packer
//
// Upstream feeder for the 4-bit ESP32 stream FIFO. Each completed Apple II
// bus cycle arrives as a one-cycle strobe carrying address, data and R/W.
// Cycles that fall inside the [ADDR_LO, ADDR_HI] window (and are writes, or
// reads when CAPTURE_READS=1) are packed into tagged 32-bit words and written
// to the stream FIFO one cycle later.
//
// When the FIFO has no room, captures are dropped and counted. Once room
// returns, a DROP word carrying the number of lost captures is written so the
// consumer can detect and size every gap in the stream.
//
// Word formats:
//   DATA : [31:28]=4'hA [27]=rw_n [26:24]=seq [23:8]=addr [7:0]=data
//   DROP : [31:28]=4'hD [27:16]=12'h000 [15:0]=pending drop count
//
// Handshake: there is no ready path back to the bus; a strobe is either
// captured (written next cycle) or dropped. The FIFO side is a plain write
// strobe: fifo_data_out is valid only in cycles where fifo_wr_en=1, and it
// holds its last value otherwise. Writes are only issued when both
// fifo_full and fifo_almost_full were low in the deciding cycle; the
// almost_full margin absorbs the one-cycle registered write path.
//
// Ports:
//   clk              system clock (same domain as the stream FIFO)
//   rst              synchronous, active-high reset
//   enable           capture enable; low suppresses new captures only
//   bus_strobe       one-cycle pulse per completed bus cycle
//   bus_addr         bus address, valid with bus_strobe
//   bus_data         bus data, valid with bus_strobe
//   bus_rw_n         1 = read, 0 = write, valid with bus_strobe
//   fifo_full        stream FIFO full
//   fifo_almost_full stream FIFO count >= depth-2
//   clear_stats      one-cycle pulse; clears drop_count and overflow_flag
//   fifo_wr_en       one-cycle write pulse to the stream FIFO
//   fifo_data_out    word written when fifo_wr_en=1
//   drop_count       total dropped captures, saturating at 16'hFFFF
//   overflow_flag    sticky; set on any drop
// ---------------------------------------------------------------------------
module a2bus_capture_packer #(
    parameter logic [15:0] ADDR_LO       = 16'hC000,
    parameter logic [15:0] ADDR_HI       = 16'hC0FF,
    parameter bit          CAPTURE_READS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bus_strobe,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_data,
    input  logic        bus_rw_n,
    input  logic        fifo_full,
    input  logic        fifo_almost_full,
    input  logic        clear_stats,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_data_out,
    output logic [15:0] drop_count,
    output logic        overflow_flag
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  seq;
    logic [15:0] pending;

    logic        in_window;
    logic        match;
    logic        space;
    logic        drop;
    logic [15:0] pending_inc;
    logic [15:0] pending_next;
    logic [15:0] drop_count_inc;
    logic [31:0] data_word;
    logic [31:0] drop_word;

    // -----------------------------------------------------------------------
    // Capture qualification and word assembly
    // -----------------------------------------------------------------------
    always_comb begin
        in_window = (bus_addr >= ADDR_LO) && (bus_addr <= ADDR_HI);
        match     = enable && bus_strobe && in_window
                    && (!bus_rw_n || CAPTURE_READS);
        space     = !fifo_almost_full && !fifo_full;

        // In DRAIN every match is dropped, even when space has returned, so
        // that nothing overtakes the DROP word that reports the gap.
        drop      = match && ((state == ST_DRAIN) || !space);

        pending_inc    = (pending == 16'hFFFF) ? pending : pending + 16'd1;
        pending_next   = match ? pending_inc : pending;
        drop_count_inc = (drop_count == 16'hFFFF) ? drop_count
                                                  : drop_count + 16'd1;

        data_word = {4'hA, bus_rw_n, seq, bus_addr, bus_data};
        // The DROP word includes a drop that happens in its own emission cycle.
        drop_word = {4'hD, 12'h000, pending_next};
    end

    // -----------------------------------------------------------------------
    // Capture FSM with registered FIFO write outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            seq           <= 3'd0;
            pending       <= 16'd0;
            fifo_wr_en    <= 1'b0;
            fifo_data_out <= 32'h0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (match && space) begin
                        fifo_wr_en    <= 1'b1;
                        fifo_data_out <= data_word;
                        seq           <= seq + 3'd1;
                    end else if (match) begin
                        pending <= 16'd1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (space) begin
                        fifo_wr_en    <= 1'b1;
                        fifo_data_out <= drop_word;
                        // A match in the emission cycle is reported twice:
                        // in this DROP word and as the start of the next gap,
                        // which keeps the FSM in DRAIN for one more report.
                        if (match) begin
                            pending <= 16'd1;
                        end else begin
                            pending <= 16'd0;
                            state   <= ST_RUN;
                        end
                    end else begin
                        pending <= pending_next;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Drop statistics; clear_stats wins over a coincident drop
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count    <= 16'd0;
            overflow_flag <= 1'b0;
        end else if (clear_stats) begin
            drop_count    <= 16'd0;
            overflow_flag <= 1'b0;
        end else if (drop) begin
            drop_count    <= drop_count_inc;
            overflow_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_a2bus_capture_packer.sv
// ---------------------------------------------------------------------------
// Testbench for a2bus_capture_packer.
//
// Two instances share the bus and FIFO inputs: u_dut captures reads and
// writes, u_dut_wo captures writes only and has its own enable so it only
// sees traffic during the filter scenario. Expected FIFO words and the cycle
// on which each must appear are queued as stimulus is driven; monitors pop
// and compare them whenever fifo_wr_en is seen.
// ---------------------------------------------------------------------------
module tb_a2bus_capture_packer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        en_wo;
    logic        bus_strobe;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_rw_n;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        clear_stats;

    logic        fifo_wr_en;
    logic [31:0] fifo_data_out;
    logic [15:0] drop_count;
    logic        overflow_flag;

    logic        wo_wr_en;
    logic [31:0] wo_data_out;
    logic [15:0] wo_drop_count;
    logic        wo_overflow_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          exp_t[$];
    logic [31:0] exp_q_wo[$];
    int          exp_t_wo[$];

    logic [2:0]  seq_m;

    a2bus_capture_packer #(
        .ADDR_LO(16'hC000), .ADDR_HI(16'hC0FF), .CAPTURE_READS(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .bus_strobe(bus_strobe),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw_n(bus_rw_n),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .clear_stats(clear_stats), .fifo_wr_en(fifo_wr_en),
        .fifo_data_out(fifo_data_out), .drop_count(drop_count),
        .overflow_flag(overflow_flag)
    );

    a2bus_capture_packer #(
        .ADDR_LO(16'hC000), .ADDR_HI(16'hC0FF), .CAPTURE_READS(1'b0)
    ) u_dut_wo (
        .clk(clk), .rst(rst), .enable(en_wo), .bus_strobe(bus_strobe),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw_n(bus_rw_n),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .clear_stats(clear_stats), .fifo_wr_en(wo_wr_en),
        .fifo_data_out(wo_data_out), .drop_count(wo_drop_count),
        .overflow_flag(wo_overflow_flag)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got word %h at cycle %0d, expected no write",
                         fifo_data_out, cyc);
            end else begin
                logic [31:0] ew;
                int          et;
                ew = exp_q.pop_front();
                et = exp_t.pop_front();
                if (fifo_data_out !== ew || cyc != et) begin
                    errors++;
                    $display("FAIL wr_word: got %h at cycle %0d, expected %h at cycle %0d",
                             fifo_data_out, cyc, ew, et);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wo_wr_en === 1'b1) begin
            checks++;
            if (exp_q_wo.size() == 0) begin
                errors++;
                $display("FAIL wo_wr_unexpected: got word %h at cycle %0d, expected no write",
                         wo_data_out, cyc);
            end else begin
                logic [31:0] ew;
                int          et;
                ew = exp_q_wo.pop_front();
                et = exp_t_wo.pop_front();
                if (wo_data_out !== ew || cyc != et) begin
                    errors++;
                    $display("FAIL wo_wr_word: got %h at cycle %0d, expected %h at cycle %0d",
                             wo_data_out, cyc, ew, et);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus_addr   = a;
        bus_data   = d;
        bus_rw_n   = rw;
        bus_strobe = 1'b1;
        tick();
        bus_strobe = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w, input int dly);
        exp_q.push_back(w);
        exp_t.push_back(cyc + dly);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        seq_m = 3'd0;
    endtask

    function automatic logic [31:0] mk_data(input logic rw, input logic [2:0] s,
                                            input logic [15:0] a, input logic [7:0] d);
        return {4'hA, rw, s, a, d};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_fifo: got wr_en=%b data=%h, expected 0 and 00000000",
                     fifo_wr_en, fifo_data_out);
        end
        checks++;
        if (drop_count !== 16'h0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats: got drop_count=%h overflow=%b, expected 0000 and 0",
                     drop_count, overflow_flag);
        end
        checks++;
        if (wo_wr_en !== 1'b0 || wo_data_out !== 32'h0 || wo_drop_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_wo: got wr_en=%b data=%h drop=%h, expected zeros",
                     wo_wr_en, wo_data_out, wo_drop_count);
        end
        rst   = 1'b0;
        seq_m = 3'd0;
        tick();
    endtask

    task automatic test_filter();
        en_wo = 1'b1;
        expect_word(32'hA0C0305A, 1);
        exp_q_wo.push_back(32'hA0C0305A);
        exp_t_wo.push_back(cyc + 1);
        strobe(16'hC030, 8'h5A, 1'b0);
        strobe(16'hBFFF, 8'h22, 1'b0);
        strobe(16'hC100, 8'h33, 1'b0);
        expect_word(32'hA9C0FF11, 1);
        strobe(16'hC0FF, 8'h11, 1'b1);
        seq_m = 3'd2;
        repeat (3) tick();
        en_wo = 1'b0;
        checks++;
        if (exp_q.size() != 0 || exp_q_wo.size() != 0) begin
            errors++;
            $display("FAIL filter_pending: got %0d/%0d words outstanding, expected 0/0",
                     exp_q.size(), exp_q_wo.size());
        end
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            logic        rw;
            a  = 16'hC000 + 16'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            rw = 1'($urandom_range(0, 1));
            expect_word(mk_data(rw, seq_m, a, d), 1);
            seq_m = seq_m + 3'd1;
            strobe(a, d, rw);
        end
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0 || seq_m !== 3'd1) begin
            errors++;
            $display("FAIL seq_wrap_pending: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        fifo_almost_full = 1'b1;
        strobe(16'hC010, 8'h01, 1'b0);
        strobe(16'hC011, 8'h02, 1'b1);
        strobe(16'hC012, 8'h03, 1'b0);
        fifo_almost_full = 1'b0;
        expect_word(32'hD0000003, 1);
        tick();
        checks++;
        if (drop_count !== 16'd3 || overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_stats: got drop_count=%0d overflow=%b, expected 3 and 1",
                     drop_count, overflow_flag);
        end
        expect_word(mk_data(1'b0, seq_m, 16'hC020, 8'h44), 1);
        seq_m = seq_m + 3'd1;
        strobe(16'hC020, 8'h44, 1'b0);
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_pending: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_drop_during_emission();
        fifo_almost_full = 1'b1;
        strobe(16'hC001, 8'h10, 1'b0);
        strobe(16'hC002, 8'h20, 1'b0);
        fifo_almost_full = 1'b0;
        expect_word(32'hD0000003, 1);
        expect_word(32'hD0000001, 2);
        strobe(16'hC003, 8'h30, 1'b0);
        tick();
        expect_word(mk_data(1'b1, seq_m, 16'hC0AA, 8'h55), 1);
        seq_m = seq_m + 3'd1;
        strobe(16'hC0AA, 8'h55, 1'b1);
        repeat (2) tick();
        checks++;
        if (drop_count !== 16'd6) begin
            errors++;
            $display("FAIL emission_drop_count: got %0d, expected 6", drop_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL emission_pending: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_saturation_clear();
        fifo_full  = 1'b1;
        bus_addr   = 16'hC080;
        bus_data   = 8'h77;
        bus_rw_n   = 1'b0;
        bus_strobe = 1'b1;
        repeat (70000) tick();
        bus_strobe = 1'b0;
        checks++;
        if (drop_count !== 16'hFFFF || overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_stats: got drop_count=%h overflow=%b, expected ffff and 1",
                     drop_count, overflow_flag);
        end
        fifo_full = 1'b0;
        expect_word(32'hD000FFFF, 1);
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checks++;
        if (drop_count !== 16'h0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_stats: got drop_count=%h overflow=%b, expected 0000 and 0",
                     drop_count, overflow_flag);
        end
        // Clear coinciding with a drop: stats stay clear, the drop is still reported.
        fifo_almost_full = 1'b1;
        clear_stats      = 1'b1;
        strobe(16'hC0C0, 8'h99, 1'b0);
        clear_stats      = 1'b0;
        fifo_almost_full = 1'b0;
        expect_word(32'hD0000001, 1);
        tick();
        checks++;
        if (drop_count !== 16'h0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_drop: got drop_count=%h overflow=%b, expected 0000 and 0",
                     drop_count, overflow_flag);
        end
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sat_pending: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        fifo_almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe(16'hC040 + 16'(i), 8'(i), 1'b0);
        end
        fifo_almost_full = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_data_out !== 32'h0 ||
            drop_count !== 16'h0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got wr_en=%b data=%h drop=%h ovf=%b, expected all zero",
                     fifo_wr_en, fifo_data_out, drop_count, overflow_flag);
        end
        rst   = 1'b0;
        seq_m = 3'd0;
        repeat (3) tick();
        expect_word(mk_data(1'b0, 3'd0, 16'hC0EE, 8'hBE), 1);
        strobe(16'hC0EE, 8'hBE, 1'b0);
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pending: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    // ---------------- main sequence and final report ----------------
    initial begin
        rst              = 1'b1;
        enable           = 1'b1;
        en_wo            = 1'b0;
        bus_strobe       = 1'b0;
        bus_addr         = 16'h0;
        bus_data         = 8'h0;
        bus_rw_n         = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        clear_stats      = 1'b0;
        seq_m            = 3'd0;

        test_reset();
        test_filter();
        test_seq_wrap();
        test_backpressure();
        test_drop_during_emission();
        test_saturation_clear();
        test_reset_mid_drain();

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0 || exp_q_wo.size() != 0) begin
            errors++;
            $display("FAIL final_queues: got %0d/%0d words outstanding, expected 0/0",
                     exp_q.size(), exp_q_wo.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
